// File: rtl/elastic_slip_ctrl.sv
// Elastic buffer pointer controller with centre-fill start-up and slip recentring.
// Read pointer jumps to half a buffer behind the write pointer when the fill leaves the window.
module elastic_slip_ctrl #(
  parameter int ADDRBIT   = 4,
  parameter int WIN_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wren,
  input  logic                 rden,
  input  logic [WIN_WIDTH-1:0] winsize,
  input  logic                 forceslip,
  input  logic                 clrcnt,
  output logic [ADDRBIT-1:0]   wraddr,
  output logic [ADDRBIT-1:0]   rdaddr,
  output logic                 rd_ack,
  output logic [ADDRBIT:0]     fill,
  output logic                 slip_ovf,
  output logic                 slip_udf,
  output logic [7:0]           slipcnt
);

  localparam int PW = ADDRBIT + 1;
  localparam logic [PW-1:0] DEPTH_P  = PW'(1 << ADDRBIT);
  localparam logic [PW-1:0] CENTER_P = PW'(1 << (ADDRBIT - 1));

  typedef enum logic {FILL, RUN} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] wptr_reg, wptr_next;
  logic [PW-1:0] rptr_reg, rptr_next;
  logic          slip_ovf_reg, slip_udf_reg;
  logic [7:0]    slipcnt_reg, slipcnt_next;

  logic [PW-1:0] fill_cur;
  logic [PW-1:0] lo_thr, hi_thr;
  logic          ovf_now, udf_now, ack_now;

  assign fill_cur = wptr_reg - rptr_reg;
  assign lo_thr   = {{(PW-WIN_WIDTH){1'b0}}, winsize};
  assign hi_thr   = DEPTH_P - lo_thr;

  always_comb begin
    state_next = state_reg;
    wptr_next  = wptr_reg + {{ADDRBIT{1'b0}}, wren};
    rptr_next  = rptr_reg;
    ovf_now    = 1'b0;
    udf_now    = 1'b0;
    ack_now    = 1'b0;
    unique case (state_reg)
      FILL: begin
        if (fill_cur == CENTER_P) state_next = RUN;
      end
      RUN: begin
        ack_now = rden;
        udf_now = rden && (fill_cur <= lo_thr);
        ovf_now = wren && (fill_cur >= hi_thr);
        // Both slip directions recentre relative to the post-write pointer.
        if (udf_now || ovf_now) rptr_next = wptr_next - CENTER_P;
        else                    rptr_next = rptr_reg + {{ADDRBIT{1'b0}}, rden};
      end
    endcase
    if (forceslip) begin
      state_next = FILL;
      wptr_next  = '0;
      rptr_next  = '0;
      ovf_now    = 1'b0;
      udf_now    = 1'b0;
    end
  end

  always_comb begin
    slipcnt_next = slipcnt_reg;
    if (clrcnt)
      slipcnt_next = '0;
    else if ((ovf_now || udf_now) && (slipcnt_reg != 8'hFF))
      slipcnt_next = slipcnt_reg + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FILL;
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      slip_ovf_reg <= 1'b0;
      slip_udf_reg <= 1'b0;
      slipcnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wptr_reg     <= wptr_next;
      rptr_reg     <= rptr_next;
      slip_ovf_reg <= ovf_now;
      slip_udf_reg <= udf_now;
      slipcnt_reg  <= slipcnt_next;
    end
  end

  assign wraddr   = wptr_reg[ADDRBIT-1:0];
  assign rdaddr   = rptr_reg[ADDRBIT-1:0];
  assign rd_ack   = ack_now;
  assign fill     = fill_cur;
  assign slip_ovf = slip_ovf_reg;
  assign slip_udf = slip_udf_reg;
  assign slipcnt  = slipcnt_reg;

endmodule

// File: tb/tb_elastic_slip_ctrl.sv
// Directed bench for elastic_slip_ctrl: vector table for fill/run/slip behaviour,
// hand sequences for forceslip, counter saturation, clear priority and mid-run reset.
module tb_elastic_slip_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wren, rden, forceslip, clrcnt;
  logic [1:0] winsize;
  logic [3:0] wraddr, rdaddr;
  logic       rd_ack;
  logic [4:0] fill;
  logic       slip_ovf, slip_udf;
  logic [7:0] slipcnt;

  int tests = 0;
  int fails = 0;

  elastic_slip_ctrl #(.ADDRBIT(4), .WIN_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .wren(wren), .rden(rden), .winsize(winsize),
    .forceslip(forceslip), .clrcnt(clrcnt), .wraddr(wraddr), .rdaddr(rdaddr),
    .rd_ack(rd_ack), .fill(fill), .slip_ovf(slip_ovf), .slip_udf(slip_udf),
    .slipcnt(slipcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic w;
    logic r;
    logic ack;
    int   fill;
    logic ovf;
    logic udf;
    int   cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic w, input logic r, input logic ack,
                              input int f, input logic ovf, input logic udf, input int cnt);
    vec_t v;
    v.w = w; v.r = r; v.ack = ack; v.fill = f; v.ovf = ovf; v.udf = udf; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; rd_ack is sampled before the edge, registers after it.
  task automatic cyc(input logic w, input logic r, input logic fs, input logic cc, output logic ack);
    wren = w; rden = r; forceslip = fs; clrcnt = cc;
    #1 ack = rd_ack;
    @(posedge clk);
    #1;
  endtask

  logic ack_s;
  int   exp_cnt;

  initial begin
    rst = 1'b1; wren = 0; rden = 0; forceslip = 0; clrcnt = 0; winsize = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fill", int'(fill), 0);
    chk("reset_ack", int'(rd_ack), 0);
    chk("reset_cnt", int'(slipcnt), 0);
    chk("reset_wraddr", int'(wraddr), 0);
    chk("reset_pulses", int'({slip_ovf, slip_udf}), 0);
    rst = 1'b0;

    for (int i = 1; i <= 8; i++) add(1, 1, 0, i, 0, 0, 0);
    add(0, 1, 0, 8, 0, 0, 0);
    for (int i = 0; i < 100; i++) add(1, 1, 1, 8, 0, 0, 0);
    for (int i = 7; i >= 2; i--) add(0, 1, 1, i, 0, 0, 0);
    add(0, 1, 1, 8, 0, 1, 1);
    add(0, 0, 0, 8, 0, 0, 1);
    for (int i = 9; i <= 14; i++) add(1, 0, 0, i, 0, 0, 1);
    add(1, 0, 0, 8, 1, 0, 2);
    add(0, 0, 0, 8, 0, 0, 2);

    foreach (vecs[k]) begin
      cyc(vecs[k].w, vecs[k].r, 1'b0, 1'b0, ack_s);
      chk($sformatf("v%0d_ack", k), int'(ack_s), int'(vecs[k].ack));
      chk($sformatf("v%0d_fill", k), int'(fill), vecs[k].fill);
      chk($sformatf("v%0d_ovf", k), int'(slip_ovf), int'(vecs[k].ovf));
      chk($sformatf("v%0d_udf", k), int'(slip_udf), int'(vecs[k].udf));
      chk($sformatf("v%0d_cnt", k), int'(slipcnt), vecs[k].cnt);
    end

    // forceslip in RUN discards the coincident write and keeps slipcnt
    cyc(1, 0, 1, 0, ack_s);
    chk("fs_wraddr", int'(wraddr), 0);
    chk("fs_rdaddr", int'(rdaddr), 0);
    chk("fs_fill", int'(fill), 0);
    chk("fs_cnt", int'(slipcnt), 2);
    cyc(0, 1, 0, 0, ack_s);
    chk("fs_fill_state_ack", int'(ack_s), 0);

    for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 0, ack_s);
    chk("refill_fill", int'(fill), 8);
    cyc(0, 0, 0, 1, ack_s);
    chk("clr_cnt", int'(slipcnt), 0);
    cyc(0, 1, 0, 0, ack_s);
    chk("rerun_ack", int'(ack_s), 1);
    chk("rerun_fill", int'(fill), 7);
    cyc(1, 0, 0, 0, ack_s);
    chk("rerun_fill8", int'(fill), 8);

    // Saturation: winsize 3 makes every sixth read an underflow slip
    winsize = 2'd3;
    exp_cnt = 0;
    for (int k = 1; k <= 260; k++) begin
      repeat (6) cyc(0, 1, 0, 0, ack_s);
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      if (k == 1 || k == 255 || k == 260) begin
        chk($sformatf("sat%0d_cnt", k), int'(slipcnt), exp_cnt);
        chk($sformatf("sat%0d_udf", k), int'(slip_udf), 1);
        chk($sformatf("sat%0d_fill", k), int'(fill), 8);
      end
    end

    repeat (5) cyc(0, 1, 0, 0, ack_s);
    chk("pre_clr_fill", int'(fill), 3);
    cyc(0, 1, 0, 1, ack_s);
    chk("clr_slip_cnt", int'(slipcnt), 0);
    chk("clr_slip_udf", int'(slip_udf), 1);

    // Reset asserted mid-run takes effect without a clock edge
    repeat (6) cyc(0, 1, 0, 0, ack_s);
    chk("pre_rst_cnt", int'(slipcnt), 1);
    wren = 1; rden = 1;
    #2 rst = 1'b1;
    #1;
    chk("arst_fill", int'(fill), 0);
    chk("arst_ack", int'(rd_ack), 0);
    chk("arst_cnt", int'(slipcnt), 0);
    chk("arst_udf", int'(slip_udf), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    winsize = 2'd2;
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 1, 0, 0, ack_s);
      if (i == 8) begin
        chk("post_rst_ack", int'(ack_s), 0);
        chk("post_rst_fill", int'(fill), 8);
      end
    end
    cyc(0, 1, 0, 0, ack_s);
    chk("post_rst_transition_ack", int'(ack_s), 0);
    cyc(0, 1, 0, 0, ack_s);
    chk("post_rst_run_ack", int'(ack_s), 1);
    chk("post_rst_run_fill", int'(fill), 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/elastic_slip_ctrl.md
ELASTIC_SLIP_CTRL -- requirements
Module: elastic_slip_ctrl

Interface
REQ-001 The block SHALL have parameter ADDRBIT, default 4, buffer address width (DEPTH = 2^ADDRBIT, CENTER = 2^(ADDRBIT-1)).
REQ-002 The block SHALL have parameter WIN_WIDTH, default 2, slip threshold width; legal range 1..ADDRBIT-1.
REQ-003 The block SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port wren  in  1  write strobe, one entry per cycle.
REQ-006 The block SHALL have port rden  in  1  read request strobe.
REQ-007 The block SHALL have port winsize  in  WIN_WIDTH  slip margin in entries.
REQ-008 The block SHALL have port forceslip  in  1  synchronous re-initialise.
REQ-009 The block SHALL have port clrcnt  in  1  synchronous clear of slipcnt.
REQ-010 The block SHALL have port wraddr  out  ADDRBIT  memory write address.
REQ-011 The block SHALL have port rdaddr  out  ADDRBIT  memory read address.
REQ-012 The block SHALL have port rd_ack  out  1  read accepted this cycle.
REQ-013 The block SHALL have port fill  out  ADDRBIT+1  current occupancy.
REQ-014 The block SHALL have port slip_ovf  out  1  one-cycle overflow-slip pulse.
REQ-015 The block SHALL have port slip_udf  out  1  one-cycle underflow-slip pulse.
REQ-016 The block SHALL have port slipcnt  out  8  saturating slip event count.

Function
REQ-017 Internal pointers wptr, rptr SHALL be ADDRBIT+1 bits; wraddr/rdaddr = low ADDRBIT bits; fill = (wptr - rptr) mod 2^(ADDRBIT+1), derived from registers only.
REQ-018 States SHALL be FILL and RUN; FILL on reset and after forceslip.
REQ-019 FILL: wren increments wptr; rden ignored, rd_ack = 0; state moves to RUN at the clock edge where registered fill == CENTER (a write that cycle still counts).
REQ-020 RUN: wren increments wptr; rden increments rptr; rd_ack = rden (combinational, read at current rdaddr).
REQ-021 Thresholds SHALL be lo = winsize zero-extended and hi = DEPTH - winsize, compared against registered fill.
REQ-022 RUN underflow: rden with fill <= lo SHALL set rptr <= wptr_next - CENTER; rd_ack still 1 (repeat slip).
REQ-023 RUN overflow: wren with fill >= hi SHALL set rptr <= wptr_next - CENTER (drop slip); wptr_next includes this cycle's write.
REQ-024 Underflow and overflow conditions SHALL be mutually exclusive by the WIN_WIDTH range; no tie-break logic is required.
REQ-025 slip_ovf/slip_udf SHALL be registered and pulse high exactly one cycle after the slip edge.
REQ-026 slipcnt SHALL increment on each slip, saturate at 255, and clear on clrcnt; clrcnt wins over a coincident increment.
REQ-027 forceslip SHALL zero wptr/rptr, enter FILL, and clear the pulses next cycle; wren that cycle is discarded; slipcnt is retained.
REQ-028 Pointer arithmetic SHALL wrap modulo 2^(ADDRBIT+1) with no other overflow handling.

Reset
REQ-029 Asserting rst SHALL immediately set wptr = rptr = 0, state FILL, rd_ack 0, fill 0, slip_ovf 0, slip_udf 0, slipcnt 0.
REQ-030 Reset asserted mid-operation SHALL override all inputs; after release, behaviour SHALL be identical to power-up.

Verification (ADDRBIT=4, WIN_WIDTH=2)
REQ-031 Reset release, rden held 1, 8 writes -> rd_ack 0 throughout FILL; RUN entered; rd_ack 1 from the following cycle.
REQ-032 RUN, fill 8, wren=rden=1 for 100 cycles -> fill stays 8, no slip pulses, slipcnt 0.
REQ-033 winsize=2, RUN at fill 8, rden only -> 6 reads bring fill to 2; the 7th read recentres, fill 8 next cycle, slip_udf one pulse, slipcnt 1.
REQ-034 winsize=2, RUN at fill 8, wren only -> 6 writes bring fill to 14; the 7th write gives fill 8, slip_ovf one pulse.
REQ-035 forceslip with wren=1 in RUN -> next cycle wraddr 0, rdaddr 0, fill 0, FILL state, slipcnt unchanged.
REQ-036 Drive 260 slips -> slipcnt holds 255; clrcnt coincident with a slip -> slipcnt 0.
